branch_predictor_table: RTL and testbench
=========================================

# branch_predictor_table

Parametrised branch predictor for the five-stage RV32I pipeline. It replaces the single 2-bit FSM predictor with a table of saturating counters, selectable as bimodal or gshare. Lookup is combinational in the decode stage and feeds the predictor PC mux in the same cycle. Update is registered at branch resolution in the memory stage, and the block keeps branch and misprediction statistics.

## Interface
Parameters:
- ENTRIES, 16, number of counters; power of two, 2..256; IDX_W = log2(ENTRIES).
- CTR_BITS, 2, counter width, 1..4.
- MODE, 0, 0 = bimodal, 1 = gshare.
- ADDR_WIDTH, 32, PC/offset width.

Ports:
- clk  in  1  pipeline clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- branch_decode_sig  in  1  decode-stage instruction is a conditional branch.
- in_addr  in  ADDR_WIDTH  PC of decode-stage instruction.
- offset  in  ADDR_WIDTH  branch immediate from imm_gen.
- prediction  out  1  predict taken.
- branch_addr  out  ADDR_WIDTH  predicted target.
- lookup_idx  out  IDX_W  table index used for this lookup; the pipeline carries it to MEM alongside the predict bit.
- branch_mem_sig  in  1  update valid: MEM-stage instruction is a conditional branch.
- upd_idx  in  IDX_W  lookup_idx returned from MEM.
- upd_predicted  in  1  prediction made for that branch.
- actual_branch_decision  in  1  resolved direction.
- stat_clear  in  1  zero both statistics counters.
- stat_branches  out  32  resolved branches.
- stat_mispredicts  out  32  resolved branches with upd_predicted != actual_branch_decision.

## Operation
- Index generation:
  - Bimodal: idx = in_addr[IDX_W+1:2].
  - Gshare: idx = in_addr[IDX_W+1:2] XOR ghr, where ghr is an IDX_W-bit global history register.
  - lookup_idx = idx, always driven, independent of branch_decode_sig.
- Lookup:
  - prediction = branch_decode_sig AND table[idx] MSB AND NOT rst.
  - branch_addr = in_addr + offset, modulo 2^ADDR_WIDTH, with wrap ignored.
- Update, when branch_mem_sig = 1:
  - table[upd_idx] increments if taken, decrements if not, saturating at 0 and 2^CTR_BITS-1.
  - Gshare only: ghr <= {ghr[IDX_W-2:0], actual_branch_decision}. History is non-speculative.
  - stat_branches += 1.
  - stat_mispredicts += 1 if upd_predicted != actual_branch_decision.
  - Both statistics counters saturate at 32'hFFFFFFFF.
- stat_clear: both statistics counters go to 0 next cycle. It has priority over a coincident increment.
- Reset:
  - Every counter resets to weakly-not-taken, 2^(CTR_BITS-1)-1. For CTR_BITS = 1 that value is 0.
  - ghr = 0, stat_branches = 0, stat_mispredicts = 0, prediction = 0.
  - rst overrides a coincident update and stat_clear.
- Reset mid-operation: in-flight updates arriving after rst deassertion are applied normally to the freshly reset table.

## Timing
- Lookup: zero-cycle, combinational, from in_addr, offset, branch_decode_sig and registered table/ghr.
- Update: written on the clock edge where branch_mem_sig = 1; visible to lookups from the next cycle.
- Same-cycle lookup and update of the same index: lookup sees the pre-update value (read-before-write). Likewise, a gshare lookup uses the pre-shift ghr.
- Statistics: registered; an increment is visible the cycle after the update edge.
- No stall or back-pressure; one update per cycle maximum.

## Structure
- Package branch_predictor_pkg:
  - mode constants MODE_BIMODAL = 0, MODE_GSHARE = 1;
  - function ctr_init(CTR_BITS) returning the reset counter value;
  - function clog2.
- Sub-module sat_counter: parameter W; ports clk, rst, en, up, init value, q. The table is ENTRIES instances or an equivalent generate loop. The flop array is acceptable up to 256 entries.
- The cpu top-level changes:
  - widen id_ex and ex_mem by IDX_W to carry lookup_idx;
  - drive upd_predicted from the existing carried predict bit.

## Test plan
- Reset, then lookup with in_addr = 0x100, offset = 0x20, branch_decode_sig = 1 -> prediction = 0, branch_addr = 0x120, stats = 0.
- Bimodal, CTR_BITS = 2: two taken updates on idx 5 with upd_predicted = 0 -> lookup of PC 0x14 predicts 1; stat_branches = 2, stat_mispredicts = 2. Four more taken updates -> counter held at 3. One not-taken update -> still predicts 1. A second not-taken -> predicts 0.
- Same-cycle update (taken, idx 3, counter at 1) and lookup of PC 0x0C -> prediction = 0 that cycle, 1 the next.
- Gshare, ENTRIES = 16: updates taken, not-taken, taken -> ghr = 4'b0101. A lookup at PC 0x0 gives lookup_idx = 5, and PC 0x14 gives lookup_idx = 0.
- Aliasing and wrap: in_addr = 0xFFFFFFF0, offset = 0x20 -> branch_addr = 0x00000010. PCs 0x04 and 0x44 with ENTRIES = 16 return the same lookup_idx = 1.
- stat_clear asserted on the same edge as a mispredicted update -> both stats read 0. rst asserted on the same edge as an update -> counter at ctr_init and ghr = 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared constants and helper functions for the branch predictor table.
package branch_predictor_pkg;

    localparam int unsigned MODE_BIMODAL = 0;
    localparam int unsigned MODE_GSHARE  = 1;
    localparam int unsigned STAT_W       = 32;

    // Ceiling log2; returns 0 for a value of 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

    // Weakly-not-taken reset value: 2^(bits-1)-1, which is 0 for a 1-bit counter.
    function automatic int unsigned ctr_init(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_table_sat_counter.sv
// Saturating up/down counter with a parameterised reset value.
module sat_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic [W-1:0] init,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] CTR_MAX = '1;

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Step towards the requested direction, holding at either end.
    always_comb begin
        q_d = q_q;
        if (en) begin
            if (up && (q_q != CTR_MAX)) begin
                q_d = q_q + W'(1);
            end else if (!up && (q_q != '0)) begin
                q_d = q_q - W'(1);
            end
        end
    end

    // Counter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= init;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/branch_predictor_table.sv
// Table of saturating counters (bimodal or gshare) with lookup in decode
// and registered update at branch resolution, plus branch statistics.
module branch_predictor_table
    import branch_predictor_pkg::*;
#(
    parameter  int unsigned ENTRIES    = 16,
    parameter  int unsigned CTR_BITS   = 2,
    parameter  int unsigned MODE       = 0,
    parameter  int unsigned ADDR_WIDTH = 32,
    localparam int unsigned IDX_W      = clog2(ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  branch_decode_sig,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [ADDR_WIDTH-1:0] offset,
    output logic                  prediction,
    output logic [ADDR_WIDTH-1:0] branch_addr,
    output logic [IDX_W-1:0]      lookup_idx,
    input  logic                  branch_mem_sig,
    input  logic [IDX_W-1:0]      upd_idx,
    input  logic                  upd_predicted,
    input  logic                  actual_branch_decision,
    input  logic                  stat_clear,
    output logic [STAT_W-1:0]     stat_branches,
    output logic [STAT_W-1:0]     stat_mispredicts
);

    localparam logic [CTR_BITS-1:0] CTR_RST  = CTR_BITS'(ctr_init(CTR_BITS));
    localparam logic [STAT_W-1:0]   STAT_MAX = '1;

    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [IDX_W-1:0]    pc_idx;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    ghr_q;
    logic [IDX_W-1:0]    ghr_d;
    logic [STAT_W-1:0]   branches_q;
    logic [STAT_W-1:0]   branches_d;
    logic [STAT_W-1:0]   mispredicts_q;
    logic [STAT_W-1:0]   mispredicts_d;
    logic                unused_addr;

    // Word-aligned PC bits select the entry; upper and byte bits do not.
    assign pc_idx      = in_addr[IDX_W+1:2];
    assign unused_addr = ^{in_addr[ADDR_WIDTH-1:IDX_W+2], in_addr[1:0]};

    // Lookup index: raw PC bits, or hashed with the committed history.
    always_comb begin
        idx = pc_idx;
        if (MODE == MODE_GSHARE) begin
            idx = pc_idx ^ ghr_q;
        end
    end

    assign lookup_idx  = idx;
    assign prediction  = branch_decode_sig & ctr_q[idx][CTR_BITS-1] & ~rst;
    assign branch_addr = in_addr + offset;

    // One counter per entry; only the addressed entry moves on an update.
    for (genvar g = 0; g < ENTRIES; g++) begin : g_table
        sat_counter #(
            .W(CTR_BITS)
        ) u_ctr (
            .clk  (clk),
            .rst  (rst),
            .en   (branch_mem_sig && (upd_idx == IDX_W'(g))),
            .up   (actual_branch_decision),
            .init (CTR_RST),
            .q    (ctr_q[g])
        );
    end

    // Next history and statistics; clear wins over a coincident increment.
    always_comb begin
        ghr_d         = ghr_q;
        branches_d    = branches_q;
        mispredicts_d = mispredicts_q;
        if ((MODE == MODE_GSHARE) && branch_mem_sig) begin
            ghr_d = IDX_W'({ghr_q, actual_branch_decision});
        end
        if (stat_clear) begin
            branches_d    = '0;
            mispredicts_d = '0;
        end else if (branch_mem_sig) begin
            if (branches_q != STAT_MAX) begin
                branches_d = branches_q + STAT_W'(1);
            end
            if ((upd_predicted != actual_branch_decision) && (mispredicts_q != STAT_MAX)) begin
                mispredicts_d = mispredicts_q + STAT_W'(1);
            end
        end
    end

    // History and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q         <= '0;
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else begin
            ghr_q         <= ghr_d;
            branches_q    <= branches_d;
            mispredicts_q <= mispredicts_d;
        end
    end

    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;

endmodule

// File: tb/tb_branch_predictor_table.sv
// Self-checking bench: a bimodal and a gshare instance driven in parallel,
// compared against a behavioural table/history model.
module tb_branch_predictor_table;

    localparam int unsigned N    = 16;
    localparam int unsigned CMAX = 3;
    localparam int unsigned CINI = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_decode_sig;
    logic [31:0] in_addr;
    logic [31:0] offset;
    logic        branch_mem_sig;
    logic [3:0]  upd_idx;
    logic        upd_predicted;
    logic        actual_branch_decision;
    logic        stat_clear;

    logic        b_pred, g_pred;
    logic [31:0] b_addr, g_addr;
    logic [3:0]  b_idx, g_idx;
    logic [31:0] b_br, b_mis, g_br, g_mis;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Model state.
    int unsigned m_bim [N];
    int unsigned m_gsh [N];
    int unsigned m_ghr;
    logic [31:0] m_br, m_mis;
    bit          model_valid = 1'b0;

    always #5 clk = ~clk;

    branch_predictor_table #(.ENTRIES(16), .CTR_BITS(2), .MODE(0), .ADDR_WIDTH(32)) u_bim (
        .clk(clk), .rst(rst), .branch_decode_sig(branch_decode_sig), .in_addr(in_addr),
        .offset(offset), .prediction(b_pred), .branch_addr(b_addr), .lookup_idx(b_idx),
        .branch_mem_sig(branch_mem_sig), .upd_idx(upd_idx), .upd_predicted(upd_predicted),
        .actual_branch_decision(actual_branch_decision), .stat_clear(stat_clear),
        .stat_branches(b_br), .stat_mispredicts(b_mis)
    );

    branch_predictor_table #(.ENTRIES(16), .CTR_BITS(2), .MODE(1), .ADDR_WIDTH(32)) u_gsh (
        .clk(clk), .rst(rst), .branch_decode_sig(branch_decode_sig), .in_addr(in_addr),
        .offset(offset), .prediction(g_pred), .branch_addr(g_addr), .lookup_idx(g_idx),
        .branch_mem_sig(branch_mem_sig), .upd_idx(upd_idx), .upd_predicted(upd_predicted),
        .actual_branch_decision(actual_branch_decision), .stat_clear(stat_clear),
        .stat_branches(g_br), .stat_mispredicts(g_mis)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_lookup(input logic dec, input logic [31:0] pc, input logic [31:0] off);
        branch_decode_sig = dec;
        in_addr           = pc;
        offset            = off;
    endtask

    task automatic set_update(input logic mem, input logic [3:0] idx, input logic pr, input logic act);
        branch_mem_sig         = mem;
        upd_idx                = idx;
        upd_predicted          = pr;
        actual_branch_decision = act;
    endtask

    // Apply one clock edge of behaviour to the model.
    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_bim[i] = CINI;
                m_gsh[i] = CINI;
            end
            m_ghr = 0;
            m_br  = 0;
            m_mis = 0;
        end else begin
            if (branch_mem_sig) begin
                if (actual_branch_decision) begin
                    if (m_bim[upd_idx] < CMAX) m_bim[upd_idx]++;
                    if (m_gsh[upd_idx] < CMAX) m_gsh[upd_idx]++;
                end else begin
                    if (m_bim[upd_idx] > 0) m_bim[upd_idx]--;
                    if (m_gsh[upd_idx] > 0) m_gsh[upd_idx]--;
                end
                m_ghr = ((m_ghr * 2) + (actual_branch_decision ? 1 : 0)) % N;
            end
            if (stat_clear) begin
                m_br  = 0;
                m_mis = 0;
            end else if (branch_mem_sig) begin
                if (m_br != 32'hFFFF_FFFF) m_br++;
                if ((upd_predicted != actual_branch_decision) && (m_mis != 32'hFFFF_FFFF)) m_mis++;
            end
        end
    endtask

    // Check lookups before the edge, clock, then check statistics after it.
    task automatic do_cycle();
        int unsigned bi, gi;
        logic        eb, eg;
        #1;
        check("b_addr", b_addr, in_addr + offset);
        check("g_addr", g_addr, in_addr + offset);
        if (rst) begin
            check("b_pred_rst", 32'(b_pred), 32'd0);
            check("g_pred_rst", 32'(g_pred), 32'd0);
        end
        if (model_valid) begin
            bi = (in_addr / 4) % N;
            gi = bi ^ m_ghr;
            eb = branch_decode_sig && (m_bim[bi] >= 2) && !rst;
            eg = branch_decode_sig && (m_gsh[gi] >= 2) && !rst;
            check("b_idx", 32'(b_idx), bi);
            check("g_idx", 32'(g_idx), gi);
            check("b_pred", 32'(b_pred), 32'(eb));
            check("g_pred", 32'(g_pred), 32'(eg));
        end
        @(posedge clk);
        model_edge();
        if (rst) model_valid = 1'b1;
        #1;
        check("b_branches", b_br, m_br);
        check("b_mispred", b_mis, m_mis);
        check("g_branches", g_br, m_br);
        check("g_mispred", g_mis, m_mis);
    endtask

    task automatic idle_inputs();
        rst        = 1'b0;
        stat_clear = 1'b0;
        set_lookup(1'b0, 32'h0, 32'h0);
        set_update(1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        do_cycle();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();

        // Reset with a branch lookup in progress.
        rst = 1'b1;
        set_lookup(1'b1, 32'h100, 32'h20);
        do_cycle();
        rst = 1'b0;
        #1;
        check("post_rst_pred", 32'(b_pred), 32'd0);
        check("post_rst_addr", b_addr, 32'h120);
        check("post_rst_br", b_br, 32'd0);
        do_cycle();

        // Bimodal saturation walk on index 5.
        set_lookup(1'b1, 32'h14, 32'h0);
        set_update(1'b1, 4'd5, 1'b0, 1'b1);
        do_cycle();
        do_cycle();
        set_update(1'b0, 4'd5, 1'b0, 1'b0);
        #1;
        check("bim5_taken", 32'(b_pred), 32'd1);
        check("two_branches", b_br, 32'd2);
        check("two_mispred", b_mis, 32'd2);
        set_update(1'b1, 4'd5, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) do_cycle();
        set_update(1'b1, 4'd5, 1'b1, 1'b0);
        do_cycle();
        set_update(1'b0, 4'd5, 1'b0, 1'b0);
        #1;
        check("bim5_after_1nt", 32'(b_pred), 32'd1);
        set_update(1'b1, 4'd5, 1'b1, 1'b0);
        do_cycle();
        set_update(1'b0, 4'd5, 1'b0, 1'b0);
        #1;
        check("bim5_after_2nt", 32'(b_pred), 32'd0);

        // Same-cycle update and lookup of index 3 (counter at reset value 1).
        set_lookup(1'b1, 32'h0C, 32'h0);
        set_update(1'b1, 4'd3, 1'b0, 1'b1);
        #1;
        check("rbw_same_cycle", 32'(b_pred), 32'd0);
        do_cycle();
        set_update(1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        check("rbw_next_cycle", 32'(b_pred), 32'd1);
        do_cycle();

        // Gshare history: T, NT, T from reset gives 4'b0101.
        do_reset();
        set_update(1'b1, 4'd9, 1'b1, 1'b1);
        do_cycle();
        set_update(1'b1, 4'd9, 1'b1, 1'b0);
        do_cycle();
        set_update(1'b1, 4'd9, 1'b1, 1'b1);
        do_cycle();
        set_update(1'b0, 4'd0, 1'b0, 1'b0);
        set_lookup(1'b1, 32'h0, 32'h0);
        #1;
        check("gsh_idx_pc0", 32'(g_idx), 32'd5);
        set_lookup(1'b1, 32'h14, 32'h0);
        #1;
        check("gsh_idx_pc14", 32'(g_idx), 32'd0);
        do_cycle();

        // Address wrap and index aliasing.
        set_lookup(1'b1, 32'hFFFF_FFF0, 32'h20);
        #1;
        check("addr_wrap", b_addr, 32'h0000_0010);
        set_lookup(1'b1, 32'h04, 32'h0);
        #1;
        check("alias_04", 32'(b_idx), 32'd1);
        set_lookup(1'b1, 32'h44, 32'h0);
        #1;
        check("alias_44", 32'(b_idx), 32'd1);
        do_cycle();

        // stat_clear beats a coincident mispredicted update.
        stat_clear = 1'b1;
        set_update(1'b1, 4'd2, 1'b1, 1'b0);
        do_cycle();
        stat_clear = 1'b0;
        set_update(1'b0, 4'd0, 1'b0, 1'b0);
        check("clear_br", b_br, 32'd0);
        check("clear_mis", b_mis, 32'd0);

        // Reset beats a coincident taken update on index 5.
        rst = 1'b1;
        set_update(1'b1, 4'd5, 1'b0, 1'b1);
        do_cycle();
        idle_inputs();
        set_lookup(1'b1, 32'h14, 32'h0);
        #1;
        check("rst_wins_ctr", 32'(b_pred), 32'd0);
        check("rst_wins_ghr", 32'(g_idx), 32'd5);
        do_cycle();

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 63) == 0);
            stat_clear = ($urandom_range(0, 15) == 0);
            set_lookup(1'($urandom), $urandom, $urandom);
            set_update(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
            do_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
